// File: rtl/guffin_vend_ctrl.sv
// guffin_vend_ctrl: coin credit accumulation, vend handshake with timeout,
// and coin-at-a-time change/refund payout for the guffin vending machine.
module guffin_vend_ctrl #(
  parameter int PRICE_Q      = 3,   // price in quarters, 1..3
  parameter int VEND_TIMEOUT = 255  // cycles to wait for vend_ack, 2..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_quarter,
  input  logic       coin_half,
  input  logic       coin_dollar,
  input  logic       cancel,
  input  logic       vend_ack,
  input  logic       hopper_ready,
  output logic       vend_req,
  output logic       pay_quarter,
  output logic       pay_half,
  output logic       coin_reject,
  output logic       vend_fault,
  output logic [2:0] credit,
  output logic [6:0] state_oh,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  localparam logic [2:0] PRICE    = 3'(PRICE_Q);
  localparam logic [7:0] TMO_LAST = 8'(VEND_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] credit_q, credit_d;
  logic [7:0] tmo_q, tmo_d;
  logic       vend_req_q, vend_req_d;
  logic       pay_q_q, pay_q_d;
  logic       pay_h_q, pay_h_d;
  logic       reject_q, reject_d;
  logic       fault_q, fault_d;
  logic       busy_q, busy_d;

  // With exactly one pulse the pulse vector is already the coin value (1/2/4).
  logic [2:0] coin_val;
  logic       any_coin, multi_coin;
  logic [2:0] sum;

  assign coin_val   = {coin_dollar, coin_half, coin_quarter};
  assign any_coin   = |coin_val;
  assign multi_coin = (coin_quarter & coin_half) | (coin_quarter & coin_dollar) |
                      (coin_half & coin_dollar);
  assign sum        = credit_q + coin_val;

  // Next-state, credit and registered-output decode.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmo_d    = tmo_q;
    pay_q_d  = 1'b0;
    pay_h_d  = 1'b0;
    reject_d = 1'b0;
    fault_d  = 1'b0;
    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (state_q == S_CREDIT && cancel) begin
          // Refund wins over a same-cycle coin; the coin goes back.
          reject_d = any_coin;
          state_d  = S_CHANGE;
        end else if (multi_coin) begin
          reject_d = 1'b1;
        end else begin
          credit_d = sum;
          if (sum >= PRICE) begin
            state_d = S_VEND;
            tmo_d   = 8'd0;
          end else if (sum != 3'd0) begin
            state_d = S_CREDIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_VEND: begin
        reject_d = any_coin;
        if (vend_ack) begin
          credit_d = credit_q - PRICE;
          state_d  = (credit_d != 3'd0) ? S_CHANGE : S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          // Dispenser never answered: refund everything.
          fault_d = 1'b1;
          state_d = S_CHANGE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_CHANGE: begin
        reject_d = any_coin;
        if (hopper_ready) begin
          if (credit_q >= 3'd2) begin
            pay_h_d  = 1'b1;
            credit_d = credit_q - 3'd2;
          end else begin
            pay_q_d  = 1'b1;
            credit_d = credit_q - 3'd1;
          end
          if (credit_d == 3'd0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    vend_req_d = (state_d == S_VEND);
    busy_d     = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  // State and output registers; reset forfeits any pending change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      credit_q   <= 3'd0;
      tmo_q      <= 8'd0;
      vend_req_q <= 1'b0;
      pay_q_q    <= 1'b0;
      pay_h_q    <= 1'b0;
      reject_q   <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      tmo_q      <= tmo_d;
      vend_req_q <= vend_req_d;
      pay_q_q    <= pay_q_d;
      pay_h_q    <= pay_h_d;
      reject_q   <= reject_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
    end
  end

  assign vend_req    = vend_req_q;
  assign pay_quarter = pay_q_q;
  assign pay_half    = pay_h_q;
  assign coin_reject = reject_q;
  assign vend_fault  = fault_q;
  assign credit      = credit_q;
  assign state_oh    = 7'b0000001 << credit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_guffin_vend_ctrl.sv
// Directed bench for guffin_vend_ctrl (PRICE_Q=3, VEND_TIMEOUT=4).
module tb_guffin_vend_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_quarter, coin_half, coin_dollar, cancel, vend_ack, hopper_ready;
  logic       vend_req, pay_quarter, pay_half, coin_reject, vend_fault, busy;
  logic [2:0] credit;
  logic [6:0] state_oh;

  int checks = 0;
  int errors = 0;

  guffin_vend_ctrl #(.PRICE_Q(3), .VEND_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .coin_quarter(coin_quarter), .coin_half(coin_half), .coin_dollar(coin_dollar),
    .cancel(cancel), .vend_ack(vend_ack), .hopper_ready(hopper_ready),
    .vend_req(vend_req), .pay_quarter(pay_quarter), .pay_half(pay_half),
    .coin_reject(coin_reject), .vend_fault(vend_fault),
    .credit(credit), .state_oh(state_oh), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full observable state in one call.
  task automatic chk_all(input string tag, input logic [2:0] cr, input logic vr,
                         input logic pq, input logic ph, input logic rj,
                         input logic vf, input logic bz);
    logic [6:0] oh;
    oh = 7'b0000001 << cr;
    chk({tag, ".credit"}, {5'd0, credit}, {5'd0, cr});
    chk({tag, ".state_oh"}, {1'b0, state_oh}, {1'b0, oh});
    chk({tag, ".vend_req"}, {7'd0, vend_req}, {7'd0, vr});
    chk({tag, ".pay_quarter"}, {7'd0, pay_quarter}, {7'd0, pq});
    chk({tag, ".pay_half"}, {7'd0, pay_half}, {7'd0, ph});
    chk({tag, ".coin_reject"}, {7'd0, coin_reject}, {7'd0, rj});
    chk({tag, ".vend_fault"}, {7'd0, vend_fault}, {7'd0, vf});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, bz});
  endtask

  initial begin
    reset = 1'b1;
    coin_quarter = 0; coin_half = 0; coin_dollar = 0;
    cancel = 0; vend_ack = 0; hopper_ready = 0;
    #12;
    chk_all("reset", 3'd0, 0, 0, 0, 0, 0, 0);
    chk("reset.state_oh_lit", {1'b0, state_oh}, 8'h01);
    reset = 1'b0;

    // 1: three quarters, vend, ack with no change
    coin_quarter = 1; tick(); coin_quarter = 0;
    chk_all("t1.q1", 3'd1, 0, 0, 0, 0, 0, 0);
    coin_quarter = 1; tick(); coin_quarter = 0;
    chk_all("t1.q2", 3'd2, 0, 0, 0, 0, 0, 0);
    coin_quarter = 1; tick(); coin_quarter = 0;
    chk_all("t1.q3", 3'd3, 1, 0, 0, 0, 0, 1);
    tick();
    chk_all("t1.wait", 3'd3, 1, 0, 0, 0, 0, 1);
    vend_ack = 1; tick(); vend_ack = 0;
    chk_all("t1.ack", 3'd0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_all("t1.idle", 3'd0, 0, 0, 0, 0, 0, 0);

    // 2: half + dollar = 6, vend, change half then quarter
    hopper_ready = 1;
    coin_half = 1; tick(); coin_half = 0;
    chk_all("t2.half", 3'd2, 0, 0, 0, 0, 0, 0);
    coin_dollar = 1; tick(); coin_dollar = 0;
    chk_all("t2.dollar", 3'd6, 1, 0, 0, 0, 0, 1);
    chk("t2.state_oh_lit", {1'b0, state_oh}, 8'h40);
    vend_ack = 1; tick(); vend_ack = 0;
    chk_all("t2.ack", 3'd3, 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("t2.payh", 3'd1, 0, 0, 1, 0, 0, 1);
    tick();
    chk_all("t2.payq", 3'd0, 0, 1, 0, 0, 0, 0);
    tick();
    chk_all("t2.idle", 3'd0, 0, 0, 0, 0, 0, 0);
    hopper_ready = 0;

    // 3: half then cancel, payout stalled by hopper
    coin_half = 1; tick(); coin_half = 0;
    chk_all("t3.half", 3'd2, 0, 0, 0, 0, 0, 0);
    cancel = 1; tick(); cancel = 0;
    chk_all("t3.cancel", 3'd2, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("t3.stall", 3'd2, 0, 0, 0, 0, 0, 1);
    end
    hopper_ready = 1; tick(); hopper_ready = 0;
    chk_all("t3.payh", 3'd0, 0, 0, 1, 0, 0, 0);
    tick();
    chk_all("t3.idle", 3'd0, 0, 0, 0, 0, 0, 0);

    // 4: double coin rejected; coin during VEND rejected
    coin_quarter = 1; coin_half = 1; tick(); coin_quarter = 0; coin_half = 0;
    chk_all("t4.multi", 3'd0, 0, 0, 0, 1, 0, 0);
    tick();
    chk_all("t4.multi_end", 3'd0, 0, 0, 0, 0, 0, 0);
    coin_dollar = 1; tick(); coin_dollar = 0;
    chk_all("t4.dollar", 3'd4, 1, 0, 0, 0, 0, 1);
    coin_quarter = 1; tick(); coin_quarter = 0;
    chk_all("t4.vend_coin", 3'd4, 1, 0, 0, 1, 0, 1);
    vend_ack = 1; tick(); vend_ack = 0;
    chk_all("t4.ack", 3'd1, 0, 0, 0, 0, 0, 1);
    hopper_ready = 1; tick(); hopper_ready = 0;
    chk_all("t4.payq", 3'd0, 0, 1, 0, 0, 0, 0);
    // cancel + coin in CREDIT: coin rejected, refund honoured
    coin_quarter = 1; tick(); coin_quarter = 0;
    chk_all("t4.q", 3'd1, 0, 0, 0, 0, 0, 0);
    cancel = 1; coin_half = 1; tick(); cancel = 0; coin_half = 0;
    chk_all("t4.cancel_coin", 3'd1, 0, 0, 0, 1, 0, 1);
    hopper_ready = 1; tick(); hopper_ready = 0;
    chk_all("t4.refund", 3'd0, 0, 1, 0, 0, 0, 0);
    // cancel + coin in IDLE: coin accepted, cancel ignored
    cancel = 1; coin_quarter = 1; tick(); cancel = 0; coin_quarter = 0;
    chk_all("t4.idle_cancel", 3'd1, 0, 0, 0, 0, 0, 0);
    cancel = 1; tick(); cancel = 0;
    hopper_ready = 1; tick(); hopper_ready = 0;
    chk_all("t4.cleanup", 3'd0, 0, 1, 0, 0, 0, 0);

    // 5: timeout after 4 VEND cycles, full refund
    coin_dollar = 1; tick(); coin_dollar = 0;
    chk_all("t5.v1", 3'd4, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("t5.vwait", 3'd4, 1, 0, 0, 0, 0, 1);
    end
    tick();
    chk_all("t5.fault", 3'd4, 0, 0, 0, 0, 1, 1);
    hopper_ready = 1; tick();
    chk_all("t5.payh1", 3'd2, 0, 0, 1, 0, 0, 1);
    tick(); hopper_ready = 0;
    chk_all("t5.payh2", 3'd0, 0, 0, 1, 0, 0, 0);
    tick();
    chk_all("t5.idle", 3'd0, 0, 0, 0, 0, 0, 0);
    // ack on the expiry cycle wins
    coin_dollar = 1; tick(); coin_dollar = 0;
    tick(); tick(); tick();
    chk_all("t5b.last", 3'd4, 1, 0, 0, 0, 0, 1);
    vend_ack = 1; tick(); vend_ack = 0;
    chk_all("t5b.ack", 3'd1, 0, 0, 0, 0, 0, 1);
    hopper_ready = 1; tick(); hopper_ready = 0;
    chk_all("t5b.payq", 3'd1 - 3'd1, 0, 1, 0, 0, 0, 0);

    // 6: async reset while change is pending
    coin_dollar = 1; tick(); coin_dollar = 0;
    vend_ack = 1; tick(); vend_ack = 0;
    chk_all("t6.change", 3'd1, 0, 0, 0, 0, 0, 1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk_all("t6.reset", 3'd0, 0, 0, 0, 0, 0, 0);
    chk("t6.state_oh_lit", {1'b0, state_oh}, 8'h01);
    #2 reset = 1'b0;
    hopper_ready = 1; tick(); hopper_ready = 0;
    chk_all("t6.after", 3'd0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
